// File: rtl/ps2_pkg.sv
// ps2_pkg: shared definitions for the PS/2 keyboard controller.
//   kbd_state_e    controller state enumeration
//   PS2_*          PS/2 command and response byte values
//   is_consumed()  true for response bytes the controller absorbs and never
//                  forwards to the scancode decoder
package ps2_pkg;

  typedef enum logic [3:0] {
    INIT_SEND,
    INIT_ACK,
    INIT_BAT,
    IDLE,
    CMD_SEND,
    CMD_ACK,
    DATA_SEND,
    DATA_ACK,
    FAULT
  } kbd_state_e;

  localparam logic [7:0] PS2_CMD_RESET    = 8'hFF;
  localparam logic [7:0] PS2_CMD_SET_LED  = 8'hED;
  localparam logic [7:0] PS2_RSP_ACK      = 8'hFA;
  localparam logic [7:0] PS2_RSP_RESEND   = 8'hFE;
  localparam logic [7:0] PS2_RSP_BAT_OK   = 8'hAA;
  localparam logic [7:0] PS2_RSP_ECHO     = 8'hEE;
  localparam logic [7:0] PS2_RSP_BAT_FAIL = 8'hFC;

  function automatic logic is_consumed(input logic [7:0] b);
    return (b == PS2_RSP_ACK)    || (b == PS2_RSP_RESEND) ||
           (b == PS2_RSP_BAT_OK) || (b == PS2_RSP_ECHO)   ||
           (b == PS2_RSP_BAT_FAIL);
  endfunction

endpackage

// File: rtl/ps2_kbd_ctrl.sv
// ps2_kbd_ctrl: PS/2 keyboard host controller. Resets the keyboard, waits for
// its self-test result, forwards scancodes and retries commands that are
// NAKed or unanswered, latching a fault once the retry budget is spent.
// Optional build macro PS2_LED_SYNC_EN adds the Set-LED (0xED) command path.
//
// Parameters
//   TIMEOUT    clk cycles to wait for a keyboard response before resending
//   MAX_RETRY  resends allowed per command byte before FAULT
// Ports
//   clk, reset             rising-edge clock, synchronous active-high reset
//   rx_data, rx_valid      received byte and its one-cycle strobe
//   tx_data, tx_req        command byte to the transceiver and its request
//   tx_ready               transceiver idle; a byte moves when tx_req&tx_ready
//   alpha_led, turbo_led   requested Caps / Scroll LED states
//   scancode, trigger      forwarded byte and its one-cycle strobe
//   kbd_ok, kbd_fault      keyboard initialised / retry limit exhausted
module ps2_kbd_ctrl
  import ps2_pkg::*;
#(
  parameter int TIMEOUT   = 2500000,
  parameter int MAX_RETRY = 3
) (
  input  logic       clk,
  input  logic       reset,
  input  logic [7:0] rx_data,
  input  logic       rx_valid,
  output logic [7:0] tx_data,
  output logic       tx_req,
  input  logic       tx_ready,
  input  logic       alpha_led,
  input  logic       turbo_led,
  output logic [7:0] scancode,
  output logic       trigger,
  output logic       kbd_ok,
  output logic       kbd_fault
);

  localparam int TMR_W = (TIMEOUT > 1) ? $clog2(TIMEOUT + 1) : 1;
  localparam int RTY_W = $clog2(MAX_RETRY + 2);
  // Counting from TIMEOUT-1 down to zero gives TIMEOUT cycles in a wait state.
  localparam logic [TMR_W-1:0] TMR_LOAD = TMR_W'(TIMEOUT - 1);

  kbd_state_e       state_q, state_d;
  logic [7:0]       tx_data_q, tx_data_d;
  logic             tx_req_q, tx_req_d;
  logic [7:0]       scancode_q, scancode_d;
  logic             trigger_q, trigger_d;
  logic             kbd_ok_q, kbd_ok_d;
  logic             kbd_fault_q, kbd_fault_d;
  logic [RTY_W-1:0] retry_q, retry_d;
  logic [TMR_W-1:0] timer_q, timer_d;

  logic       tx_done, rsp_ack, rsp_resend, rsp_bat_ok, rsp_bat_fail, expired;
  logic       retry_req;
  kbd_state_e retry_to;

`ifdef PS2_LED_SYNC_EN
  logic       led_dirty_q, led_dirty_d;
  logic [1:0] led_sent_q, led_sent_d;
  logic [1:0] led_req;
  assign led_req = {alpha_led, turbo_led};
`else
  logic unused_led_inputs;
  assign unused_led_inputs = alpha_led | turbo_led;
`endif

  assign tx_done      = tx_req_q && tx_ready;
  assign rsp_ack      = rx_valid && (rx_data == PS2_RSP_ACK);
  assign rsp_resend   = rx_valid && (rx_data == PS2_RSP_RESEND);
  assign rsp_bat_ok   = rx_valid && (rx_data == PS2_RSP_BAT_OK);
  assign rsp_bat_fail = rx_valid && (rx_data == PS2_RSP_BAT_FAIL);
  assign expired      = (timer_q == '0);

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q     <= INIT_SEND;
      tx_data_q   <= 8'h00;
      tx_req_q    <= 1'b0;
      scancode_q  <= 8'h00;
      trigger_q   <= 1'b0;
      kbd_ok_q    <= 1'b0;
      kbd_fault_q <= 1'b0;
      retry_q     <= '0;
      timer_q     <= TMR_LOAD;
`ifdef PS2_LED_SYNC_EN
      led_dirty_q <= 1'b1;
      led_sent_q  <= 2'b00;
`endif
    end else begin
      state_q     <= state_d;
      tx_data_q   <= tx_data_d;
      tx_req_q    <= tx_req_d;
      scancode_q  <= scancode_d;
      trigger_q   <= trigger_d;
      kbd_ok_q    <= kbd_ok_d;
      kbd_fault_q <= kbd_fault_d;
      retry_q     <= retry_d;
      timer_q     <= timer_d;
`ifdef PS2_LED_SYNC_EN
      led_dirty_q <= led_dirty_d;
      led_sent_q  <= led_sent_d;
`endif
    end
  end

  always_comb begin
    state_d     = state_q;
    tx_data_d   = tx_data_q;
    tx_req_d    = tx_req_q;
    scancode_d  = scancode_q;
    trigger_d   = 1'b0;
    kbd_ok_d    = kbd_ok_q;
    kbd_fault_d = kbd_fault_q;
    retry_d     = retry_q;
    timer_d     = timer_q;
    retry_req   = 1'b0;
    retry_to    = INIT_SEND;
`ifdef PS2_LED_SYNC_EN
    led_dirty_d = led_dirty_q;
    led_sent_d  = led_sent_q;
`endif

    // Scancode forwarding is independent of the command sequencer.
    if (rx_valid && !is_consumed(rx_data) && (state_q != FAULT)) begin
      trigger_d  = 1'b1;
      scancode_d = rx_data;
    end

    case (state_q)
      INIT_SEND: begin
        if (tx_done) begin
          tx_req_d = 1'b0;
          state_d  = INIT_ACK;
          timer_d  = TMR_LOAD;
        end else begin
          tx_req_d = 1'b1;
          // Only load while idle so the byte cannot change under a pending request.
          if (!tx_req_q) tx_data_d = PS2_CMD_RESET;
        end
      end
      INIT_ACK: begin
        if (rsp_ack) begin
          retry_d = '0;
          state_d = INIT_BAT;
          timer_d = TMR_LOAD;
        end else if (rsp_resend || expired) begin
          retry_req = 1'b1;
          retry_to  = INIT_SEND;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      INIT_BAT: begin
        if (rsp_bat_ok) begin
          retry_d  = '0;
          kbd_ok_d = 1'b1;
          state_d  = IDLE;
        end else if (rsp_bat_fail || expired) begin
          // A failed self-test re-sends reset and is charged to the same
          // budget, so a permanently broken keyboard ends in FAULT.
          retry_req = 1'b1;
          retry_to  = INIT_SEND;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      IDLE: begin
`ifdef PS2_LED_SYNC_EN
        if (led_dirty_q) begin
          state_d   = CMD_SEND;
          tx_data_d = PS2_CMD_SET_LED;
        end
`endif
      end
`ifdef PS2_LED_SYNC_EN
      CMD_SEND, DATA_SEND: begin
        // tx_data was loaded on entry and is kept for any resend.
        if (tx_done) begin
          tx_req_d = 1'b0;
          state_d  = (state_q == CMD_SEND) ? CMD_ACK : DATA_ACK;
          timer_d  = TMR_LOAD;
        end else begin
          tx_req_d = 1'b1;
        end
      end
      CMD_ACK: begin
        if (rsp_ack) begin
          retry_d   = '0;
          state_d   = DATA_SEND;
          tx_data_d = {5'b0, alpha_led, 1'b0, turbo_led};
        end else if (rsp_resend || expired) begin
          retry_req = 1'b1;
          retry_to  = CMD_SEND;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
      DATA_ACK: begin
        if (rsp_ack) begin
          retry_d = '0;
          state_d = IDLE;
        end else if (rsp_resend || expired) begin
          retry_req = 1'b1;
          retry_to  = DATA_SEND;
        end else begin
          timer_d = timer_q - 1'b1;
        end
      end
`endif
      FAULT: begin
        tx_req_d = 1'b0;
      end
      default: state_d = INIT_SEND;
    endcase

    if (retry_req) begin
      if (int'(retry_q) >= MAX_RETRY) begin
        state_d     = FAULT;
        kbd_fault_d = 1'b1;
        kbd_ok_d    = 1'b0;
      end else begin
        retry_d = retry_q + 1'b1;
        state_d = retry_to;
      end
    end

`ifdef PS2_LED_SYNC_EN
    // Dirty tracks "requested LEDs differ from what the keyboard last got";
    // a change during a running sequence leaves it set so another follows.
    if ((state_q == DATA_SEND) && tx_done) begin
      led_sent_d  = {tx_data_q[2], tx_data_q[0]};
      led_dirty_d = (led_req != {tx_data_q[2], tx_data_q[0]});
    end else if ((led_req != led_sent_q) || ((state_q == IDLE) && rsp_bat_ok)) begin
      led_dirty_d = 1'b1;
    end
`endif
  end

  assign tx_data   = tx_data_q;
  assign tx_req    = tx_req_q;
  assign scancode  = scancode_q;
  assign trigger   = trigger_q;
  assign kbd_ok    = kbd_ok_q;
  assign kbd_fault = kbd_fault_q;

endmodule

// File: tb/tb_ps2_kbd_ctrl.sv
// Self-checking bench for ps2_kbd_ctrl: table of rx bytes with expected
// forwarding, hand-written sequences for init, timeout, fault and reset,
// and a scoreboard for transmitted bytes and forwarded scancodes.
module tb_ps2_kbd_ctrl;

  localparam int TO = 20;
  localparam int MR = 3;

  logic       clk = 1'b0;
  logic       reset = 1'b1;
  logic [7:0] rx_data = 8'h00;
  logic       rx_valid = 1'b0;
  logic       tx_ready = 1'b0;
  logic       alpha_led = 1'b0;
  logic       turbo_led = 1'b0;
  logic [7:0] tx_data, scancode;
  logic       tx_req, trigger, kbd_ok, kbd_fault;

  int tests = 0;
  int fails = 0;
  int tx_count = 0;
  int n_exp = 0;
  logic [7:0] exp_tx[$];
  logic [7:0] exp_sc[$];
  logic [7:0] mon_e;

  typedef struct {
    logic [7:0] b;
    bit         fwd;
  } rx_vec_t;
  rx_vec_t vecs[9];

  always #5 clk = ~clk;

  ps2_kbd_ctrl #(.TIMEOUT(TO), .MAX_RETRY(MR)) dut (
    .clk(clk), .reset(reset), .rx_data(rx_data), .rx_valid(rx_valid),
    .tx_data(tx_data), .tx_req(tx_req), .tx_ready(tx_ready),
    .alpha_led(alpha_led), .turbo_led(turbo_led),
    .scancode(scancode), .trigger(trigger),
    .kbd_ok(kbd_ok), .kbd_fault(kbd_fault)
  );

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    tests++;
    if (act !== exp) begin
      fails++;
      $display("FAIL %s: got %0h, expected %0h", name, act, exp);
    end
  endtask

  // Monitor: a transfer is seen on the negedge before the edge that takes it.
  always @(negedge clk) begin
    if (!reset && trigger === 1'b1) begin
      if (exp_sc.size() == 0) begin
        tests++; fails++;
        $display("FAIL trigger_unexpected: got scancode %0h, expected no trigger", scancode);
      end else begin
        mon_e = exp_sc.pop_front();
        check("scancode", 32'(scancode), 32'(mon_e));
      end
    end
    if (!reset && tx_req === 1'b1 && tx_ready === 1'b1) begin
      tx_count++;
      if (exp_tx.size() == 0) begin
        tests++; fails++;
        $display("FAIL tx_unexpected: got tx_data %0h, expected no transfer", tx_data);
      end else begin
        mon_e = exp_tx.pop_front();
        check("tx_data", 32'(tx_data), 32'(mon_e));
      end
    end
  end

  task automatic expect_tx(input logic [7:0] b);
    exp_tx.push_back(b);
    n_exp++;
  endtask

  task automatic wait_tx(input int target, input int budget, output int elapsed);
    elapsed = 0;
    while (tx_count < target && elapsed < budget) begin
      @(posedge clk);
      elapsed++;
    end
    check("tx_wait", 32'(tx_count >= target), 32'd1);
  endtask

  task automatic send_rx(input logic [7:0] b, input bit fwd, input string name);
    if (fwd) exp_sc.push_back(b);
    @(posedge clk); #1;
    rx_data = b; rx_valid = 1'b1;
    @(posedge clk); #1;
    rx_valid = 1'b0;
    @(negedge clk);
    check(name, 32'(trigger), 32'(fwd));
  endtask

  task automatic do_reset();
    @(posedge clk); #1;
    tx_ready = 1'b0; rx_valid = 1'b0; reset = 1'b1;
    check("tx_pending", 32'(exp_tx.size()), 32'd0);
    repeat (3) @(posedge clk);
    #1;
    reset = 1'b0;
    tx_count = 0;
    n_exp = 0;
  endtask

`ifdef PS2_LED_SYNC_EN
  task automatic led_seq(input logic [7:0] led_byte);
    int el;
    expect_tx(8'hED);
    wait_tx(n_exp, TO, el);
    send_rx(8'hFA, 1'b0, "led_cmd_ack");
    expect_tx(led_byte);
    wait_tx(n_exp, TO, el);
    send_rx(8'hFA, 1'b0, "led_data_ack");
  endtask
`endif

  initial begin
    #1_000_000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "watchdog");
  end

  initial begin
    int el;
    vecs[0] = '{8'hF0, 1'b1};
    vecs[1] = '{8'h1C, 1'b1};
    vecs[2] = '{8'hFA, 1'b0};
    vecs[3] = '{8'hE0, 1'b1};
    vecs[4] = '{8'hFE, 1'b0};
    vecs[5] = '{8'hEE, 1'b0};
    vecs[6] = '{8'hFC, 1'b0};
    vecs[7] = '{8'hFF, 1'b1};
    vecs[8] = '{8'h5A, 1'b1};

    // Reset state
    reset = 1'b1; tx_ready = 1'b1;
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("rst_tx_req", 32'(tx_req), 32'd0);
    check("rst_tx_data", 32'(tx_data), 32'h00);
    check("rst_trigger", 32'(trigger), 32'd0);
    check("rst_scancode", 32'(scancode), 32'h00);
    check("rst_kbd_ok", 32'(kbd_ok), 32'd0);
    check("rst_kbd_fault", 32'(kbd_fault), 32'd0);

    // Normal initialisation: one 0xFF, then ACK and BAT pass
    @(posedge clk); #1;
    reset = 1'b0;
    expect_tx(8'hFF);
    wait_tx(1, TO, el);
    @(negedge clk);
    check("tx_req_drop", 32'(tx_req), 32'd0);
    send_rx(8'hFA, 1'b0, "init_ack_trig");
    check("ok_before_bat", 32'(kbd_ok), 32'd0);
    send_rx(8'hAA, 1'b0, "init_bat_trig");
    check("kbd_ok_init", 32'(kbd_ok), 32'd1);
`ifdef PS2_LED_SYNC_EN
    expect_tx(8'hED);
    wait_tx(n_exp, TO, el);
    send_rx(8'hFA, 1'b0, "led_cmd_ack");
    expect_tx(8'h00);
    wait_tx(n_exp, TO, el);
    #1 alpha_led = 1'b1;
    send_rx(8'hFA, 1'b0, "led_data_ack");
    led_seq(8'h04);
    @(posedge clk); #1 turbo_led = 1'b1;
    expect_tx(8'hED);
    expect_tx(8'hED);
    wait_tx(n_exp - 1, TO, el);
    wait_tx(n_exp, TO + 20, el);
    check("cmd_ack_timeout_gap", 32'(el >= TO && el <= TO + 4), 32'd1);
    send_rx(8'hFA, 1'b0, "led_cmd_ack");
    expect_tx(8'h05);
    wait_tx(n_exp, TO, el);
    send_rx(8'hFA, 1'b0, "led_data_ack");
`endif
    repeat (3 * TO) @(posedge clk);
    check("idle_quiet", 32'(tx_count), 32'(n_exp));

    // Forwarding table in IDLE
    for (int i = 0; i < 9; i++)
      send_rx(vecs[i].b, vecs[i].fwd, $sformatf("fwd_%0d", i));
    send_rx(8'hAA, 1'b0, "hotplug_trig");
    check("hotplug_kbd_ok", 32'(kbd_ok), 32'd1);
`ifdef PS2_LED_SYNC_EN
    led_seq({5'b0, alpha_led, 1'b0, turbo_led});
`endif
    check("sc_pending", 32'(exp_sc.size()), 32'd0);

    // Stalled transceiver, then timeout resend while waiting for ACK
    do_reset();
    repeat (2 * TO) @(posedge clk);
    @(negedge clk);
    check("stall_tx_req", 32'(tx_req), 32'd1);
    check("stall_tx_data", 32'(tx_data), 32'hFF);
    check("stall_no_xfer", 32'(tx_count), 32'd0);
    @(posedge clk); #1 tx_ready = 1'b1;
    expect_tx(8'hFF);
    expect_tx(8'hFF);
    wait_tx(1, 10, el);
    wait_tx(2, TO + 20, el);
    check("init_timeout_gap", 32'(el >= TO && el <= TO + 4), 32'd1);
    send_rx(8'hFA, 1'b0, "retry_ack_trig");
    send_rx(8'hAA, 1'b0, "retry_bat_trig");
    check("retry_kbd_ok", 32'(kbd_ok), 32'd1);

    // Four NAKs of 0xFF exhaust the retry budget
    do_reset();
    tx_ready = 1'b1;
    for (int k = 1; k <= MR + 1; k++) begin
      expect_tx(8'hFF);
      wait_tx(k, TO, el);
      send_rx(8'hFE, 1'b0, "nak_trig");
    end
    check("fault_flag", 32'(kbd_fault), 32'd1);
    check("fault_kbd_ok", 32'(kbd_ok), 32'd0);
    check("fault_tx_req", 32'(tx_req), 32'd0);
    send_rx(8'h1C, 1'b0, "fault_no_trig");
    repeat (3 * TO) @(posedge clk);
    check("fault_quiet", 32'(tx_count), 32'(MR + 1));
    check("fault_held", 32'(kbd_fault), 32'd1);

    // Reset while a request is pending
    do_reset();
    repeat (3) @(posedge clk);
    @(negedge clk);
    check("pre_reset_req", 32'(tx_req), 32'd1);
    check("post_fault_clear", 32'(kbd_fault), 32'd0);
    @(posedge clk); #1 reset = 1'b1;
    @(posedge clk);
    @(negedge clk);
    check("midrst_tx_req", 32'(tx_req), 32'd0);
    check("midrst_tx_data", 32'(tx_data), 32'h00);
    @(posedge clk); #1;
    reset = 1'b0; tx_ready = 1'b1; tx_count = 0; n_exp = 0;
    expect_tx(8'hFF);
    wait_tx(1, TO, el);
    send_rx(8'hFA, 1'b0, "reinit_ack_trig");
    send_rx(8'hAA, 1'b0, "reinit_bat_trig");
    check("reinit_kbd_ok", 32'(kbd_ok), 32'd1);
`ifdef PS2_LED_SYNC_EN
    led_seq({5'b0, alpha_led, 1'b0, turbo_led});
`endif
    repeat (5) @(posedge clk);
    check("final_tx_pending", 32'(exp_tx.size()), 32'd0);
    check("final_sc_pending", 32'(exp_sc.size()), 32'd0);

    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

endmodule
